// File: rtl/conv_pkg.sv
`default_nettype none
// ============================================================================
// Module   : conv_pkg
// Purpose  : Shared types and helpers for the convolution window fetcher:
//            fetch FSM state encoding, window slice indexing and counter
//            width calculation.
// Revision : 1.0 - initial release
// ============================================================================
package conv_pkg;

  // Fetch FSM states, explicit 2-bit encoding
  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_FETCH = 2'd1,
    ST_VALID = 2'd2,
    ST_DONE  = 2'd3
  } fetch_state_e;

  // Pixel (r,c) of a KxK window lives in slice r*K+c of the packed word
  function automatic int win_idx(input int r, input int c, input int k);
    return r * k + c;
  endfunction

  // Bits needed for a counter that must reach the value n inclusive
  function automatic int cnt_w(input int n);
    return (n < 1) ? 1 : $clog2(n + 1);
  endfunction

endpackage : conv_pkg
`default_nettype wire

// File: rtl/multiport_bram.sv
`default_nettype none
// ============================================================================
// Module   : multiport_bram
// Purpose  : One write port, RAM_PORTS registered read ports. Reads return
//            the pre-write contents on a same-cycle address collision.
//            Contents are not affected by reset.
// Revision : 1.0 - initial release
// ============================================================================
module multiport_bram #(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 6,
  parameter int RAM_PORTS  = 3
) (
  input  logic                            i_clk,
  input  logic                            i_wr_en,
  input  logic [ADDR_WIDTH-1:0]           i_w_addrs,
  input  logic [DATA_WIDTH-1:0]           i_data,
  input  logic [RAM_PORTS*ADDR_WIDTH-1:0] i_r_addrs,
  output logic [RAM_PORTS*DATA_WIDTH-1:0] o_data
);

  localparam int C_DEPTH = 2 ** ADDR_WIDTH;

  logic [DATA_WIDTH-1:0] mem_q [C_DEPTH];
  logic [DATA_WIDTH-1:0] rd_q  [RAM_PORTS];

  // Write and all reads share one edge; non-blocking update gives read-first
  always_ff @(posedge i_clk) begin
    if (i_wr_en) begin
      mem_q[i_w_addrs] <= i_data;
    end
    for (int p = 0; p < RAM_PORTS; p++) begin
      rd_q[p] <= mem_q[i_r_addrs[p*ADDR_WIDTH +: ADDR_WIDTH]];
    end
  end

  // Port 0 occupies the low slice of the packed output
  for (genvar p = 0; p < RAM_PORTS; p++) begin : g_out_pack
    assign o_data[p*DATA_WIDTH +: DATA_WIDTH] = rd_q[p];
  end

endmodule : multiport_bram
`default_nettype wire

// File: rtl/conv_window_fetch.sv
`default_nettype none
// ============================================================================
// Module   : conv_window_fetch
// Purpose  : Feature-map store plus sweep engine. Walks every KxK window
//            (stride 1, no padding) in row-major order, fetching one window
//            row per cycle from a K-port RAM, and presents each assembled
//            window on a valid/ready interface.
// Revision : 1.0 - initial release
// ============================================================================
module conv_window_fetch
  import conv_pkg::*;
#(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 6,
  parameter int KERNEL     = 3,
  parameter int IMG_W      = 8,
  parameter int IMG_H      = 8
) (
  input  logic                                i_clk,
  input  logic                                i_rst_n,
  input  logic                                i_wr_en,
  input  logic [ADDR_WIDTH-1:0]               i_w_addrs,
  input  logic [DATA_WIDTH-1:0]               i_data,
  input  logic                                i_start,
  input  logic                                i_ready,
  output logic [DATA_WIDTH*KERNEL*KERNEL-1:0] o_window,
  output logic                                o_valid,
  output logic [ADDR_WIDTH-1:0]               o_row,
  output logic [ADDR_WIDTH-1:0]               o_col,
  output logic                                o_busy,
  output logic                                o_done
);

  localparam int C_WIN_BITS = DATA_WIDTH * KERNEL * KERNEL;
  localparam int C_RCNT_W   = cnt_w(KERNEL);

  localparam logic [ADDR_WIDTH-1:0] C_IMG_W    = ADDR_WIDTH'(IMG_W);
  localparam logic [ADDR_WIDTH-1:0] C_LAST_ROW = ADDR_WIDTH'(IMG_H - KERNEL);
  localparam logic [ADDR_WIDTH-1:0] C_LAST_COL = ADDR_WIDTH'(IMG_W - KERNEL);
  localparam logic [ADDR_WIDTH-1:0] C_AONE     = ADDR_WIDTH'(1);
  localparam logic [C_RCNT_W-1:0]   C_RCNT_END = C_RCNT_W'(KERNEL);
  localparam logic [C_RCNT_W-1:0]   C_RONE     = C_RCNT_W'(1);

  // Reject geometries that cannot fit in the address space
  if (KERNEL > IMG_W || KERNEL > IMG_H || IMG_W * IMG_H > 2 ** ADDR_WIDTH) begin : g_param_check
    $error("conv_window_fetch: KERNEL must fit the image and IMG_W*IMG_H must fit ADDR_WIDTH");
  end

  fetch_state_e            state_q, state_d;
  logic [ADDR_WIDTH-1:0]   row_q, row_d;
  logic [ADDR_WIDTH-1:0]   col_q, col_d;
  logic [C_RCNT_W-1:0]     rcnt_q, rcnt_d;
  logic [C_WIN_BITS-1:0]   window_q, window_d;

  logic [ADDR_WIDTH-1:0]          w_row_base;
  logic [KERNEL*ADDR_WIDTH-1:0]   w_raddrs;
  logic [KERNEL*DATA_WIDTH-1:0]   w_rdata;

  // Start address of the window row currently being issued
  assign w_row_base = (row_q + ADDR_WIDTH'(rcnt_q)) * C_IMG_W;

  // Port j reads column col+j of that row
  for (genvar j = 0; j < KERNEL; j++) begin : g_addr_gen
    assign w_raddrs[j*ADDR_WIDTH +: ADDR_WIDTH] = w_row_base + col_q + ADDR_WIDTH'(j);
  end

  multiport_bram #(
    .DATA_WIDTH (DATA_WIDTH),
    .ADDR_WIDTH (ADDR_WIDTH),
    .RAM_PORTS  (KERNEL)
  ) u_bram (
    .i_clk      (i_clk),
    .i_wr_en    (i_wr_en),
    .i_w_addrs  (i_w_addrs),
    .i_data     (i_data),
    .i_r_addrs  (w_raddrs),
    .o_data     (w_rdata)
  );

  // State, position counters and window register
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      state_q  <= ST_IDLE;
      row_q    <= '0;
      col_q    <= '0;
      rcnt_q   <= '0;
      window_q <= '0;
    end else begin
      state_q  <= state_d;
      row_q    <= row_d;
      col_q    <= col_d;
      rcnt_q   <= rcnt_d;
      window_q <= window_d;
    end
  end

  // Next-state: issue K row reads, capture each one a cycle later, then hold
  always_comb begin
    state_d  = state_q;
    row_d    = row_q;
    col_d    = col_q;
    rcnt_d   = rcnt_q;
    window_d = window_q;
    case (state_q)
      ST_IDLE: begin
        if (i_start) begin
          state_d = ST_FETCH;
          row_d   = '0;
          col_d   = '0;
          rcnt_d  = '0;
        end
      end
      ST_FETCH: begin
        // RAM output now holds the row issued on the previous cycle
        if (rcnt_q != '0) begin
          for (int c = 0; c < KERNEL; c++) begin
            window_d[win_idx(int'(rcnt_q) - 1, c, KERNEL)*DATA_WIDTH +: DATA_WIDTH] =
              w_rdata[c*DATA_WIDTH +: DATA_WIDTH];
          end
        end
        if (rcnt_q == C_RCNT_END) begin
          state_d = ST_VALID;
        end else begin
          rcnt_d = rcnt_q + C_RONE;
        end
      end
      ST_VALID: begin
        if (i_ready) begin
          if (row_q == C_LAST_ROW && col_q == C_LAST_COL) begin
            state_d = ST_DONE;
          end else begin
            state_d = ST_FETCH;
            rcnt_d  = '0;
            if (col_q == C_LAST_COL) begin
              col_d = '0;
              row_d = row_q + C_AONE;
            end else begin
              col_d = col_q + C_AONE;
            end
          end
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  assign o_window = window_q;
  assign o_row    = row_q;
  assign o_col    = col_q;
  assign o_valid  = (state_q == ST_VALID);
  assign o_busy   = (state_q == ST_FETCH) || (state_q == ST_VALID);
  assign o_done   = (state_q == ST_DONE);

endmodule : conv_window_fetch
`default_nettype wire

// File: tb/tb_conv_window_fetch.sv
`default_nettype none
// ============================================================================
// Module   : tb_conv_window_fetch
// Purpose  : Directed self-checking bench for conv_window_fetch (8x8 image,
//            3x3 kernel): reset values, window contents and order, latency,
//            period, backpressure, write collision, mid-sweep reset and
//            ignored start pulses.
// Revision : 1.0 - initial release
// ============================================================================
module tb_conv_window_fetch;

  logic        clk = 1'b0;
  logic        rst_n, wr_en, start, ready;
  logic [5:0]  waddr;
  logic [7:0]  wdata;
  logic [71:0] window;
  logic        valid, busy, done;
  logic [5:0]  row, col;

  int checks = 0;
  int errors = 0;

  logic [7:0] mdl [64];

  always #5 clk = ~clk;

  conv_window_fetch #(
    .DATA_WIDTH (8),
    .ADDR_WIDTH (6),
    .KERNEL     (3),
    .IMG_W      (8),
    .IMG_H      (8)
  ) dut (
    .i_clk     (clk),
    .i_rst_n   (rst_n),
    .i_wr_en   (wr_en),
    .i_w_addrs (waddr),
    .i_data    (wdata),
    .i_start   (start),
    .i_ready   (ready),
    .o_window  (window),
    .o_valid   (valid),
    .o_row     (row),
    .o_col     (col),
    .o_busy    (busy),
    .o_done    (done)
  );

  task automatic chk(input string tag, input logic [71:0] obs, input logic [71:0] req);
    checks++;
    assert (obs === req) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, req);
    end
  endtask

  task automatic step();
    @(negedge clk);
  endtask

  function automatic logic [71:0] exp_win(input int r0, input int c0);
    logic [71:0] w;
    w = '0;
    for (int r = 0; r < 3; r++) begin
      for (int c = 0; c < 3; c++) begin
        w[(r*3+c)*8 +: 8] = mdl[(r0+r)*8 + c0 + c];
      end
    end
    return w;
  endfunction

  function automatic logic [71:0] pack9(input logic [7:0] p0, p1, p2, p3, p4,
                                        p5, p6, p7, p8);
    return {p8, p7, p6, p5, p4, p3, p2, p1, p0};
  endfunction

  // One sweep from a negedge in IDLE; optional collision write, stall,
  // spurious start pulse and mid-fetch reset
  task automatic run_sweep(input bit collide, input int stall_win, input int stall_len,
                           input int start_win, input int abort_win,
                           output int nwin, output logic [71:0] w0,
                           output logic [71:0] w6, output logic [71:0] w35);
    int cyc, last_rise, hs_cyc, stalled, er, ec;
    bit prev_valid, prev_stalled, pend_aa, fin;
    cyc = 0; last_rise = 0; hs_cyc = -10; stalled = 0; er = 0; ec = 0;
    prev_valid = 1'b0; prev_stalled = 1'b0; pend_aa = 1'b0; fin = 1'b0;
    nwin = 0; w0 = '0; w6 = '0; w35 = '0;
    ready = 1'b1;
    start = 1'b1;
    while (!fin && cyc < 600) begin
      step();
      cyc++;
      start = 1'b0;
      wr_en = 1'b0;
      // Cycle 2 is when row 1 of window (0,0) is read: collide on address 9
      if (collide && cyc == 2) begin
        wr_en = 1'b1; waddr = 6'd9; wdata = 8'hAA; pend_aa = 1'b1;
      end
      if (abort_win >= 0 && nwin == abort_win && busy && !valid) begin
        rst_n = 1'b0;
        step();
        rst_n = 1'b1;
        chk("abort_valid",  valid,  0);
        chk("abort_busy",   busy,   0);
        chk("abort_done",   done,   0);
        chk("abort_window", window, 0);
        chk("abort_row",    row,    0);
        chk("abort_col",    col,    0);
        step();
        chk("abort_no_done", done, 0);
        chk("abort_idle",    busy, 0);
        fin = 1'b1;
      end else if (done) begin
        chk("done_timing", cyc, hs_cyc + 1);
        step();
        chk("done_pulse", done, 0);
        chk("idle_busy",  busy, 0);
        fin = 1'b1;
      end else if (valid) begin
        er = nwin / 6;
        ec = nwin % 6;
        if (!prev_valid) begin
          if (nwin == 0) chk("first_valid_latency", cyc, 5);
          else if (!prev_stalled) chk("valid_period", cyc - last_rise, 5);
          last_rise = cyc;
          chk("win_data", window, exp_win(er, ec));
          chk("win_row",  row, er);
          chk("win_col",  col, ec);
          if (pend_aa && nwin == 0) begin
            mdl[9]  = 8'hAA;
            pend_aa = 1'b0;
          end
          if (nwin == start_win) start = 1'b1;
        end else begin
          chk("hold_data", window, exp_win(er, ec));
          chk("hold_row",  row, er);
          chk("hold_col",  col, ec);
        end
        if (nwin == stall_win && stalled < stall_len) begin
          ready = 1'b0;
          stalled++;
        end else begin
          ready = 1'b1;
          prev_stalled = (nwin == stall_win);
          if (nwin == 0)  w0  = window;
          if (nwin == 6)  w6  = window;
          if (nwin == 35) w35 = window;
          nwin++;
          hs_cyc = cyc;
        end
      end
      prev_valid = valid;
    end
    chk("sweep_terminated", fin, 1);
  endtask

  initial begin
    int          n;
    logic [71:0] w0, w6, w35;

    rst_n = 1'b0; wr_en = 1'b0; start = 1'b0; ready = 1'b0;
    waddr = '0; wdata = '0;
    step();
    step();
    chk("rst_valid",  valid,  0);
    chk("rst_busy",   busy,   0);
    chk("rst_done",   done,   0);
    chk("rst_window", window, 0);
    chk("rst_row",    row,    0);
    chk("rst_col",    col,    0);
    rst_n = 1'b1;

    // Preload pixel value addr+1
    for (int a = 0; a < 64; a++) begin
      wr_en = 1'b1;
      waddr = 6'(a);
      wdata = 8'(a + 1);
      mdl[a] = 8'(a + 1);
      step();
    end
    wr_en = 1'b0;

    // Full sweep: collision on addr 9, 7-cycle stall at (2,3), stray start
    run_sweep(1'b1, 15, 7, 20, -1, n, w0, w6, w35);
    chk("sweep1_count", n, 36);
    chk("sweep1_first", w0,  pack9(8'd1, 8'd2, 8'd3, 8'd9, 8'd10, 8'd11, 8'd17, 8'd18, 8'd19));
    chk("sweep1_win10", w6,  pack9(8'd9, 8'hAA, 8'd11, 8'd17, 8'd18, 8'd19, 8'd25, 8'd26, 8'd27));
    chk("sweep1_last",  w35, pack9(8'd46, 8'd47, 8'd48, 8'd54, 8'd55, 8'd56, 8'd62, 8'd63, 8'd64));

    // Reset during fetch of window 10
    run_sweep(1'b0, -1, 0, -1, 10, n, w0, w6, w35);
    chk("abort_count", n, 10);

    // Restart after reset: memory retained
    run_sweep(1'b0, -1, 0, -1, -1, n, w0, w6, w35);
    chk("sweep3_count", n, 36);
    chk("sweep3_first", w0, pack9(8'd1, 8'd2, 8'd3, 8'd9, 8'hAA, 8'd11, 8'd17, 8'd18, 8'd19));

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule : tb_conv_window_fetch
`default_nettype wire
